// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the packet-aware stream demultiplexer.
package stream_demux_pkg;

    // Packet framing: waiting for a first beat, or inside a packet.
    typedef enum logic {
        SOP = 1'b0,
        MID = 1'b1
    } demux_state_t;

    // Width of a channel index; never below one bit so ports stay legal.
    function automatic int dest_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice. Accepts a new entry whenever it is
// empty or its current entry leaves on the same edge, so it sustains one
// entry per cycle. in_ready never depends on in_valid.
module stream_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = ~full_q | out_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;

    // Load on accept (drain and reload may coincide), otherwise empty on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_packet.sv
// Packet-aware 1-to-N_OUT stream demultiplexer. The destination is taken from
// the first beat of each packet and held until the last beat. Beats go through
// a single registered stage; packets aimed at a nonexistent channel are
// swallowed and reported on drop.
//
// Handshake: a beat moves on a port in every cycle where its valid and ready
// are both high at the rising edge. up_ready is a function of registered
// state, up_dest (in the first-beat state) and dn_ready only, never of
// up_valid; dn_ready bits of channels that are not valid are ignored.
module stream_demux_packet
    import stream_demux_pkg::*;
#(
    parameter int N_OUT = 4,
    parameter int W     = 8,
    localparam int DW   = dest_width(N_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic             up_last,
    input  logic [DW-1:0]    up_dest,
    output logic [N_OUT-1:0] dn_valid,
    input  logic [N_OUT-1:0] dn_ready,
    output logic [W-1:0]     dn_data,
    output logic             dn_last,
    output logic             drop
);

    localparam int SW = W + DW + 1;

    demux_state_t  state_q, state_d;
    logic [DW-1:0] dest_q, dest_d;
    logic [DW-1:0] eff_dest;
    logic [DW-1:0] out_dest;
    logic          in_range;
    logic          up_fire;
    logic          slice_in_valid;
    logic          slice_in_ready;
    logic          slice_out_valid;
    logic          sel_ready;
    logic          drop_q;
    logic [SW-1:0] slice_in_data;
    logic [SW-1:0] slice_out_data;

    // First beat routes on its own up_dest; later beats on the latched one.
    assign eff_dest = (state_q == SOP) ? up_dest : dest_q;
    assign in_range = (int'(eff_dest) < N_OUT);

    // Discarded beats are always accepted, independent of the output stage.
    assign up_ready       = in_range ? slice_in_ready : 1'b1;
    assign up_fire        = up_valid & up_ready;
    assign slice_in_valid = up_valid & in_range;
    assign slice_in_data  = {eff_dest, up_last, up_data};

    assign {out_dest, dn_last, dn_data} = slice_out_data;
    assign drop = drop_q;

    stream_reg_slice #(
        .WIDTH (SW)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .in_data   (slice_in_data),
        .out_valid (slice_out_valid),
        .out_ready (sel_ready),
        .out_data  (slice_out_data)
    );

    // Decode the held entry's channel into one-hot valid and pick its ready.
    always_comb begin
        sel_ready = 1'b0;
        dn_valid  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (int'(out_dest) == k) begin
                sel_ready   = dn_ready[k];
                dn_valid[k] = slice_out_valid;
            end
        end
    end

    // Framing register, latched destination and registered drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SOP;
            dest_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            drop_q  <= up_fire & ~in_range;
        end
    end

    // Next framing state: track first/last beats on every accepted beat.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        if (up_fire) begin
            case (state_q)
                SOP: begin
                    if (!up_last) begin
                        state_d = MID;
                        dest_d  = up_dest;
                    end
                end
                MID: begin
                    if (up_last) begin
                        state_d = SOP;
                    end
                end
                default: state_d = SOP;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_demux_packet.sv
// Bench for stream_demux_packet: a 4-channel and a 3-channel instance share
// one stimulus/observation view selected by sel. A packet-level model keeps
// the ordered list of beats that must appear downstream and the drop pulses
// implied by out-of-range packets; directed literal checks pin latency,
// ordering and backpressure behaviour.
module tb_stream_demux_packet;

    localparam int HN = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       up_valid = 1'b0;
    logic [7:0] up_data = 8'h00;
    logic       up_last = 1'b0;
    logic [1:0] up_dest = 2'd0;
    logic [3:0] dn_ready = 4'hF;

    logic       up_ready, dn_last, drop;
    logic [3:0] dn_valid;
    logic [7:0] dn_data;

    logic       ur4, dl4, dr4, ur3, dl3, dr3;
    logic [3:0] dv4;
    logic [2:0] dv3;
    logic [7:0] dd4, dd3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [10:0] exp_q[$];
    logic        in_pkt = 1'b0;
    logic [1:0]  pkt_dest = 2'd0;
    logic        drop_exp = 1'b0;
    logic        p_stall = 1'b0, p_uv = 1'b0, p_ur = 1'b0, p_ul = 1'b0, p_last = 1'b0;
    logic [3:0]  p_dv = 4'd0;
    logic [1:0]  p_ud = 2'd0;
    logic [7:0]  p_udata = 8'd0, p_data = 8'd0;

    logic [3:0]  h_dv[0:HN-1];
    logic [7:0]  h_data[0:HN-1];
    logic        h_last[0:HN-1];
    logic        h_ur[0:HN-1];
    logic        h_drop[0:HN-1];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    stream_demux_packet #(.N_OUT(4), .W(8)) u_dut4 (
        .clk(clk), .rst(rst),
        .up_valid(up_valid & ~sel), .up_ready(ur4), .up_data(up_data),
        .up_last(up_last), .up_dest(up_dest),
        .dn_valid(dv4), .dn_ready(sel ? 4'h0 : dn_ready),
        .dn_data(dd4), .dn_last(dl4), .drop(dr4)
    );

    stream_demux_packet #(.N_OUT(3), .W(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .up_valid(up_valid & sel), .up_ready(ur3), .up_data(up_data),
        .up_last(up_last), .up_dest(up_dest),
        .dn_valid(dv3), .dn_ready(sel ? dn_ready[2:0] : 3'h0),
        .dn_data(dd3), .dn_last(dl3), .drop(dr3)
    );

    assign up_ready = sel ? ur3 : ur4;
    assign dn_valid = sel ? {1'b0, dv3} : dv4;
    assign dn_data  = sel ? dd3 : dd4;
    assign dn_last  = sel ? dl3 : dl4;
    assign drop     = sel ? dr3 : dr4;

    function automatic int ix(input int c);
        return c & (HN - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offer one beat and hold it until accepted; t is the cycle it transfers.
    task automatic send(input logic [1:0] d, input logic [7:0] data, input logic last,
                        output int t);
        t = -1;
        up_valid = 1'b1;
        up_dest  = d;
        up_data  = data;
        up_last  = last;
        for (int n = 0; n < 50 && t < 0; n++) begin
            @(negedge clk);
            if (up_ready) t = cyc;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept data=%0h", data);
        end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    // Scoreboard and protocol checks on every cycle out of reset.
    always @(negedge clk) begin : compare
        logic [1:0]  eff;
        logic [3:0]  fire_dn;
        logic [10:0] e;
        logic        ur_exp;
        logic        drop_next;
        int          ch;
        int          n_out;
        h_dv[ix(cyc)]   = dn_valid;
        h_data[ix(cyc)] = dn_data;
        h_last[ix(cyc)] = dn_last;
        h_ur[ix(cyc)]   = up_ready;
        h_drop[ix(cyc)] = drop;
        n_out = sel ? 3 : 4;
        if (rst) begin
            exp_q.delete();
            in_pkt   = 1'b0;
            pkt_dest = 2'd0;
            drop_exp = 1'b0;
            p_stall  = 1'b0;
            p_uv     = 1'b0;
        end else begin
            chk("drop", drop, drop_exp);
            chk("onehot", (dn_valid & (dn_valid - 4'd1)) == 4'd0, 1);
            if (p_stall)
                chk("stall_hold", {dn_valid, dn_last, dn_data}, {p_dv, p_last, p_data});
            if (p_uv && !p_ur)
                chk("up_protocol", {up_valid, up_last, up_dest, up_data},
                    {1'b1, p_ul, p_ud, p_udata});
            eff = in_pkt ? pkt_dest : up_dest;
            if (int'(eff) >= n_out) ur_exp = 1'b1;
            else ur_exp = (dn_valid == 4'd0) || ((dn_valid & dn_ready) != 4'd0);
            chk("up_ready", up_ready, ur_exp);
            fire_dn = dn_valid & dn_ready;
            if (fire_dn != 4'd0) begin
                ch = 0;
                for (int k = 0; k < 4; k++) if (fire_dn[k]) ch = k;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual=ch%0d/%0h required=none", ch, dn_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({ch[1:0], dn_last, dn_data} !== e) begin
                        errors++;
                        $display("FAIL beat actual=%0h required=%0h", {ch[1:0], dn_last, dn_data}, e);
                    end
                end
            end
            drop_next = 1'b0;
            if (up_valid && up_ready) begin
                if (int'(eff) >= n_out) drop_next = 1'b1;
                else exp_q.push_back({eff, up_last, up_data});
                if (!in_pkt) pkt_dest = up_dest;
                in_pkt = !up_last;
            end
            drop_exp = drop_next;
            p_stall  = (dn_valid != 4'd0) && (fire_dn == 4'd0);
            p_dv     = dn_valid;
            p_data   = dn_data;
            p_last   = dn_last;
            p_uv     = up_valid;
            p_ur     = up_ready;
            p_ul     = up_last;
            p_ud     = up_dest;
            p_udata  = up_data;
        end
    end

    task automatic drain_and_check_empty(input string name);
        repeat (3) @(posedge clk);
        #2;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin : main
        int t[0:3];
        int ta, tb, tc;

        // Reset, re-assert mid-cycle, then idle.
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("rst_dn_valid", dn_valid, 4'b0000);
        chk("rst_dn_data", dn_data, 8'h00);
        chk("rst_dn_last", dn_last, 1'b0);
        chk("rst_drop", drop, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        ta = cyc;
        repeat (5) @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            chk("idle_dn_valid", h_dv[ix(ta + i)], 4'b0000);
            chk("idle_up_ready", h_ur[ix(ta + i)], 1'b1);
            chk("idle_drop", h_drop[ix(ta + i)], 1'b0);
        end

        // Single-beat packets to every channel, back to back.
        for (int i = 0; i < 4; i++) send(2'(i), 8'hA0 + 8'(i), 1'b1, t[i]);
        drain_and_check_empty("single_empty");
        for (int i = 0; i < 4; i++) begin
            chk("single_back2back", t[i], t[0] + i);
            chk("single_dn_valid", h_dv[ix(t[0] + 1 + i)], 4'b0001 << i);
            chk("single_dn_data", h_data[ix(t[0] + 1 + i)], 8'hA0 + 8'(i));
        end

        // Multi-beat packet: destination held from the first beat.
        send(2'd2, 8'h10, 1'b0, t[0]);
        send(2'd1, 8'h11, 1'b0, t[1]);
        send(2'd1, 8'h12, 1'b0, t[2]);
        send(2'd1, 8'h13, 1'b1, t[3]);
        drain_and_check_empty("hold_empty");
        for (int i = 0; i < 4; i++) begin
            chk("hold_dn_valid", h_dv[ix(t[0] + 1 + i)], 4'b0100);
            chk("hold_dn_data", h_data[ix(t[0] + 1 + i)], 8'h10 + 8'(i));
            chk("hold_dn_last", h_last[ix(t[0] + 1 + i)], i == 3);
        end

        // Backpressure on channel 1 for three cycles.
        dn_ready = 4'b1101;
        send(2'd1, 8'h20, 1'b0, t[0]);
        fork
            send(2'd0, 8'h21, 1'b0, t[1]);
            begin
                repeat (3) @(posedge clk);
                #1 dn_ready = 4'hF;
            end
        join
        send(2'd3, 8'h22, 1'b0, t[2]);
        send(2'd2, 8'h23, 1'b1, t[3]);
        drain_and_check_empty("bp_empty");
        for (int i = 1; i <= 3; i++) begin
            chk("bp_data_held", h_data[ix(t[0] + i)], 8'h20);
            chk("bp_valid_held", h_dv[ix(t[0] + i)], 4'b0010);
            chk("bp_up_ready", h_ur[ix(t[0] + i)], 1'b0);
        end
        chk("bp_release_cycle", t[1], t[0] + 4);
        chk("bp_next_data", h_data[ix(t[0] + 5)], 8'h21);

        // Packet to 3 ends, packet to 0 follows with no bubble.
        send(2'd3, 8'h2F, 1'b0, ta);
        send(2'd1, 8'h30, 1'b1, tb);
        send(2'd0, 8'h40, 1'b1, tc);
        drain_and_check_empty("switch_empty");
        chk("switch_accept", tc, tb + 1);
        chk("switch_ch3", h_dv[ix(tb + 1)], 4'b1000);
        chk("switch_ch0", h_dv[ix(tb + 2)], 4'b0001);
        chk("switch_data", h_data[ix(tb + 2)], 8'h40);

        // Three-channel instance: out-of-range packet is dropped.
        sel = 1'b1;
        @(posedge clk); #1;
        send(2'd3, 8'h50, 1'b0, ta);
        send(2'd0, 8'h51, 1'b1, tb);
        send(2'd1, 8'h60, 1'b1, tc);
        drain_and_check_empty("oor_empty");
        chk("oor_drop0", h_drop[ix(ta + 1)], 1'b1);
        chk("oor_drop1", h_drop[ix(tb + 1)], 1'b1);
        chk("oor_no_valid0", h_dv[ix(ta + 1)], 4'b0000);
        chk("oor_no_valid1", h_dv[ix(tb + 1)], 4'b0000);
        chk("oor_next_ch1", h_dv[ix(tc + 1)], 4'b0010);
        chk("oor_next_data", h_data[ix(tc + 1)], 8'h60);
        chk("oor_next_nodrop", h_drop[ix(tc + 1)], 1'b0);

        // Reset inside a packet discards the stage and reframes.
        dn_ready = 4'h0;
        send(2'd1, 8'h70, 1'b0, ta);
        #3 rst = 1'b1;
        #1 chk("midrst_flush", dn_valid, 4'b0000);
        @(posedge clk); #1 rst = 1'b0;
        dn_ready = 4'hF;
        send(2'd0, 8'h71, 1'b1, tb);
        drain_and_check_empty("midrst_empty");
        chk("midrst_route", h_dv[ix(tb + 1)], 4'b0001);
        chk("midrst_data", h_data[ix(tb + 1)], 8'h71);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux_packet.md
Name: stream_demux_packet

Overview:
- Packet-aware 1-to-N stream demultiplexer; the inverse of the team's mux-based selectors. It steers one upstream valid/ready stream to one of N_OUT downstream channels.
- Destination is sampled on the first beat of each packet and held until the beat with last=1.
- Sits after any single-source producer that must fan out to multiple consumers.
- Single registered output stage gives full throughput with no combinational ready path from up_valid.

Parameters:
- N_OUT, 4, number of downstream channels; must be at least 2.
- W, 8, data width in bits.
- DW, $clog2(N_OUT), destination index width; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_valid  input  1  upstream beat valid.
- up_ready  output  1  upstream may transfer this cycle.
- up_data  input  W  upstream beat payload.
- up_last  input  1  final beat of packet.
- up_dest  input  DW  destination channel; sampled only on first beat of a packet.
- dn_valid  output  N_OUT  one-hot per-channel valid; at most one bit set.
- dn_ready  input  N_OUT  per-channel ready.
- dn_data  output  W  payload, shared by all channels.
- dn_last  output  1  last flag, shared.
- drop  output  1  one-cycle pulse per beat discarded for an out-of-range destination.

Behaviour:
- Transfers: an upstream transfer is up_valid & up_ready. A downstream transfer on channel k is dn_valid[k] & dn_ready[k].
- Reset (async assert, sync release): dn_valid=0, dn_data=0, dn_last=0, drop=0, state=SOP, dest register=0.
- State machine has two states:
  - SOP: waiting for the first beat of a packet.
  - MID: inside a packet.
- SOP transitions:
  - On upstream transfer with up_last=0: latch up_dest into the dest register and go to MID.
  - On upstream transfer with up_last=1 (single-beat packet): stay in SOP.
- MID transitions:
  - On upstream transfer with up_last=1: go to SOP.
  - up_dest is ignored in MID.
- Effective destination:
  - In SOP: up_dest.
  - In MID: the dest register.
- Output stage (one entry: out_full, out_dest, data, last):
  - dn_valid[k] = out_full & (out_dest==k).
  - up_ready = ~out_full | dn_ready[out_dest]. Depends on registered state and dn_ready only, never on up_valid.
  - On upstream transfer with an in-range destination: the stage loads on the same edge and dn_valid rises the next cycle.
  - Latency is 1 cycle. Simultaneous downstream drain and upstream load sustains 1 beat per cycle.
  - When the stage drains with no load: out_full clears.
- Holding while stalled: dn_data, dn_last and dn_valid stay stable while a channel is stalled (dn_ready=0).
- Channel changes: a switch to a different channel at a packet boundary needs no bubble. The old beat drains and the new beat loads on the same edge when the old channel is ready.
- Out-of-range destination (effective dest >= N_OUT, only possible when N_OUT is not a power of 2):
  - The whole packet is discarded.
  - up_ready=1 for its beats regardless of the output stage.
  - drop=1 on each discarded beat transfer.
  - The state machine still tracks up_last.
- dn_ready bits for channels that are not valid are don't-care and have no effect.
- up_valid=0 has no effect on state. up_data, up_last and up_dest are don't-care when up_valid=0.
- Upstream protocol: once up_valid=1 it is held until transfer, with payload stable. A violation is a bench assertion, not RTL handling.
- Reset mid-packet: returns to SOP and discards the output stage. The next upstream beat is treated as a first beat.

Decomposition:
- Package stream_demux_pkg:
  - typedef enum logic {SOP, MID} demux_state_t.
  - localparam helper function for the DW computation.
- Sub-module stream_reg_slice:
  - Generic one-entry valid/ready register (W+DW+1 bits, async active-high rst).
  - Instanced once for the output stage. The top keeps only the state machine, the dest register, the decode and the drop logic.

Test Plan:
1. Reset then idle:
   - Stimulus: assert rst mid-cycle, release, up_valid=0 for 5 cycles.
   - Required: dn_valid=0000, up_ready=1, drop=0 throughout.
2. Single-beat packets, all ready:
   - Stimulus: beats dest=0..3 with data 8'hA0..8'hA3, last=1, every cycle.
   - Required: dn_valid=0001,0010,0100,1000 on consecutive cycles starting 1 cycle later; dn_data matches; up_ready stays 1.
3. Multi-beat destination hold:
   - Stimulus: 4-beat packet, up_dest=2 on beat 0, then up_dest=1 on beats 1-3, data 8'h10..8'h13.
   - Required: all 4 beats appear on channel 2 only; dn_last=1 on 8'h13 only.
4. Backpressure:
   - Stimulus: dn_ready[1]=0 for 3 cycles while a packet to 1 is streaming.
   - Required: dn_data is held stable, up_ready=0 while the stage is full, no beat is lost or duplicated, and the beat order is preserved after release.
5. Channel switch with downstream ready:
   - Stimulus: packet to 3 (last beat), immediately followed by a packet to 0.
   - Required: no idle cycle between dn_valid[3] and dn_valid[0].
6. Out-of-range destination (N_OUT=3):
   - Stimulus: 2-beat packet with dest=3, then a packet with dest=1.
   - Required: drop pulses 2 cycles, no dn_valid for the dropped packet, and the next packet is delivered on channel 1.
   - Also: asserting rst during a MID state, then sending dest=0, routes to 0.
